// File: rtl/twoof5_pkg.sv
// twoof5_pkg
// Shared definitions for the serial 2-of-5 receiver:
//   - the ten 7-4-2-1-0 codewords (bit4..bit0 = weights 7,4,2,1,0)
//   - the digit reported on a code error
//   - the receiver FSM state enumeration
package twoof5_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ERR = 4'hF;

  // Digit 0 has no weight sum of 0 in 7-4-2-1-0, so it takes 7+4 = 11000.
  localparam logic [4:0] CODE_0 = 5'b11000;
  localparam logic [4:0] CODE_1 = 5'b00011;
  localparam logic [4:0] CODE_2 = 5'b00101;
  localparam logic [4:0] CODE_3 = 5'b00110;
  localparam logic [4:0] CODE_4 = 5'b01001;
  localparam logic [4:0] CODE_5 = 5'b01010;
  localparam logic [4:0] CODE_6 = 5'b01100;
  localparam logic [4:0] CODE_7 = 5'b10001;
  localparam logic [4:0] CODE_8 = 5'b10010;
  localparam logic [4:0] CODE_9 = 5'b10100;

endpackage

// File: rtl/twoof5_decode.sv
// twoof5_decode
// Combinational 2-of-5 (7-4-2-1-0) to BCD decoder.
// Ports:
//   code  in  [4:0]  codeword, bit4 = weight 7
//   digit out [3:0]  decoded digit, BCD_ERR when code is not one of the ten
//   err   out        1 when code is not one of the ten codewords
module twoof5_decode
  import twoof5_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = BCD_ERR;
    err   = 1'b1;
    case (code)
      CODE_0: begin digit = 4'd0; err = 1'b0; end
      CODE_1: begin digit = 4'd1; err = 1'b0; end
      CODE_2: begin digit = 4'd2; err = 1'b0; end
      CODE_3: begin digit = 4'd3; err = 1'b0; end
      CODE_4: begin digit = 4'd4; err = 1'b0; end
      CODE_5: begin digit = 4'd5; err = 1'b0; end
      CODE_6: begin digit = 4'd6; err = 1'b0; end
      CODE_7: begin digit = 4'd7; err = 1'b0; end
      CODE_8: begin digit = 4'd8; err = 1'b0; end
      CODE_9: begin digit = 4'd9; err = 1'b0; end
      default: begin digit = BCD_ERR; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/twoof5_serial_rx.sv
// twoof5_serial_rx
// Serial 2-of-5 receiver: collects 5-bit codewords MSB first and reports the
// decoded BCD digit one cycle after the last bit.
// Ports:
//   clk        in               clock, rising edge
//   rst_n      in               asynchronous active-low reset
//   sin_valid  in               sin_data/sof qualify this cycle
//   sin_data   in               serial codeword bit, weight-7 bit first
//   sof        in               first bit of a codeword (with sin_valid)
//   clr_cnt    in               synchronous clear of err_cnt (beats an error)
//   bcd_out    out [3:0]        decoded digit, 4'hF on error; held between pulses
//   bcd_valid  out              one-cycle pulse per completed or aborted frame
//   code_err   out              one-cycle pulse with bcd_valid on error/abort
//   err_cnt    out [ERR_CNT_W]  saturating count of code_err pulses
//   dbg_state  out              current FSM state
//
// Input qualification: the input side has no back-pressure. A bit is consumed
// on every rising edge where sin_valid=1; sof is only looked at in such cycles.
// sin_valid=0 cycles hold all state, so gaps of any length are allowed.
// Outputs are push-only: bcd_valid is a single-cycle pulse with no ready.
module twoof5_serial_rx
  import twoof5_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin_valid,
  input  logic                 sin_data,
  input  logic                 sof,
  input  logic                 clr_cnt,
  output logic [3:0]           bcd_out,
  output logic                 bcd_valid,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output state_t               dbg_state
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [4:0]           sr_q, sr_d;
  logic [3:0]           bcd_out_q, bcd_out_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic                 code_err_q, code_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Word as it will look once the current bit is shifted in; decoding this
  // directly lets the result be registered on the edge of the 5th bit.
  logic [4:0] word_next;
  logic [3:0] dec_digit;
  logic       dec_err;

  assign word_next = {sr_q[3:0], sin_data};

  twoof5_decode u_decode (
    .code  (word_next),
    .digit (dec_digit),
    .err   (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    code_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Bits without sof are not part of any frame and are dropped.
        if (sin_valid && sof) begin
          sr_d    = {4'b0000, sin_data};
          cnt_d   = 3'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          if (sof) begin
            // Abort: flag the partial frame, start a new one with this bit.
            bcd_valid_d = 1'b1;
            code_err_d  = 1'b1;
            bcd_out_d   = BCD_ERR;
            sr_d        = {4'b0000, sin_data};
            cnt_d       = 3'd1;
          end else begin
            sr_d  = word_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
              state_d     = ST_IDLE;
              bcd_valid_d = 1'b1;
              bcd_out_d   = dec_digit;
              code_err_d  = dec_err;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Counts the visible code_err pulse; clr_cnt wins when both are present.
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (code_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 5'd0;
      bcd_out_q   <= 4'h0;
      bcd_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      code_err_q  <= code_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;
  assign code_err  = code_err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_twoof5_serial_rx.sv
// tb_twoof5_serial_rx
// Directed bench for twoof5_serial_rx. Drivers push {cycle, digit, err} into
// exp_q when a pulse is due; a monitor pops on each bcd_valid and compares.
// A second instance with ERR_CNT_W=2 shares the inputs to check saturation.
module tb_twoof5_serial_rx;
  import twoof5_pkg::*;

  localparam int W = 37;  // {cycle[31:0], digit[3:0], err}

  logic       clk;
  logic       rst_n;
  logic       sin_valid;
  logic       sin_data;
  logic       sof;
  logic       clr_cnt;
  logic [3:0] bcd_out, bcd_out2;
  logic       bcd_valid, bcd_valid2;
  logic       code_err, code_err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  state_t     dbg_state, dbg_state2;

  int n_vec;
  int n_err;
  int cyc;
  logic [W-1:0] exp_q[$];

  twoof5_serial_rx #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sof(sof), .clr_cnt(clr_cnt), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .code_err(code_err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  twoof5_serial_rx #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sof(sof), .clr_cnt(clr_cnt), .bcd_out(bcd_out2), .bcd_valid(bcd_valid2),
    .code_err(code_err2), .err_cnt(err_cnt2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sin_valid = 1'b0;
      sof       = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic s, input logic d);
    sin_valid = 1'b1;
    sof       = s;
    sin_data  = d;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic expect_pulse(input logic [3:0] digit, input logic err);
    exp_q.push_back({cyc[31:0], digit, err});
  endtask

  task automatic send_frame(input logic [4:0] code, input logic [3:0] digit, input logic err);
    for (int i = 4; i >= 0; i--) send_bit(i == 4, code[i]);
    expect_pulse(digit, err);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (code_err) check("code_err_without_valid", {63'd0, bcd_valid}, 64'd1);
      if (bcd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse actual=bcd_out %0h required=no pulse", bcd_out);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(e[36:5]));
          check("bcd_out",     64'(bcd_out), 64'(e[4:1]));
          check("code_err",    64'(code_err), 64'(e[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [4:0] codes [10];

  initial begin
    codes[0] = 5'b11000; codes[1] = 5'b00011; codes[2] = 5'b00101;
    codes[3] = 5'b00110; codes[4] = 5'b01001; codes[5] = 5'b01010;
    codes[6] = 5'b01100; codes[7] = 5'b10001; codes[8] = 5'b10010;
    codes[9] = 5'b10100;

    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; sof = 1'b0; clr_cnt = 1'b0;
    #2;
    check("rst_bcd_out",   64'(bcd_out), 64'h0);
    check("rst_bcd_valid", 64'(bcd_valid), 64'h0);
    check("rst_code_err",  64'(code_err), 64'h0);
    check("rst_err_cnt",   64'(err_cnt), 64'h0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // digits 0..9 back-to-back; first sof right after reset release
    for (int d = 0; d < 10; d++) send_frame(codes[d], 4'(d), 1'b0);
    idle(2);
    check("err_cnt_after_digits", 64'(err_cnt), 64'd0);

    // invalid words
    send_frame(5'b11100, 4'hF, 1'b1);
    send_frame(5'b00000, 4'hF, 1'b1);
    send_frame(5'b01000, 4'hF, 1'b1);
    idle(2);
    check("err_cnt_after_invalid", 64'(err_cnt), 64'd3);
    check("err_cnt2_after_invalid", 64'(err_cnt2), 64'd3);

    // digit 8 with a 3-cycle gap; pulse one cycle after last bit
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(3);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    expect_pulse(4'd8, 1'b0);
    idle(4);
    check("bcd_out_hold", 64'(bcd_out), 64'd8);
    check("bcd_valid_low", 64'(bcd_valid), 64'd0);

    // abort: 3 bits of 5 (010..), then sof with digit 2 (00101)
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    expect_pulse(4'hF, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    expect_pulse(4'd2, 1'b0);
    idle(2);
    check("err_cnt_after_abort", 64'(err_cnt), 64'd1);

    // saturation of the 2-bit counter, then clear coincident with an error
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) send_frame(5'b00000, 4'hF, 1'b1);
    idle(2);
    check("err_cnt2_saturated", 64'(err_cnt2), 64'd3);
    check("err_cnt_five", 64'(err_cnt), 64'd5);
    send_frame(5'b11111, 4'hF, 1'b1);
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0;
    idle(2);
    check("err_cnt_clr_wins", 64'(err_cnt), 64'd0);
    check("err_cnt2_clr_wins", 64'(err_cnt2), 64'd0);

    // reset mid-frame, then digit 7
    send_frame(5'b00000, 4'hF, 1'b1);
    idle(2);
    check("err_cnt_before_rst", 64'(err_cnt), 64'd1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_bcd_out", 64'(bcd_out), 64'h0);
    check("midrst_err_cnt", 64'(err_cnt), 64'h0);
    check("midrst_state",   64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(codes[7], 4'd7, 1'b0);

    // drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
